// File: rtl/mips_pkg.sv
// Opcode/function constants shared by the fetch unit and the control decoder,
// plus the fetch state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic {
        REQ   = 1'b0,
        ISSUE = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential fall-through, j and jr.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] pc4;
    logic        is_j;
    logic        is_jr;

    always_comb begin
        pc4        = pc + 32'd4;
        is_j       = (instr[31:26] == OP_J);
        is_jr      = (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_JR);
        next_pc    = pc4;
        misaligned = 1'b0;
        if (is_j) begin
            // j keeps the upper nibble of the delay-slot address
            next_pc = {pc4[31:28], instr[25:0], 2'b00};
        end else if (is_jr) begin
            next_pc    = {rs_data[31:2], 2'b00};
            misaligned = |rs_data[1:0];
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches over req/ack, decodes fields
// and resolves fall-through, j and jr locally.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic [31:0] rs_data,
    output logic        instr_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [15:0] imm,
    output logic [31:0] pc,
    output logic        align_err
);

    fetch_state_t state;
    logic [31:0]  pc_reg;
    logic [31:0]  instr_reg;
    logic         align_err_reg;
    logic [31:0]  next_pc;
    logic         misaligned;

    next_pc_calc u_next_pc_calc (
        .pc         (pc_reg),
        .instr      (instr_reg),
        .rs_data    (rs_data),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= REQ;
            pc_reg        <= RESET_PC;
            instr_reg     <= 32'd0;
            align_err_reg <= 1'b0;
        end else begin
            align_err_reg <= 1'b0;
            if (state == REQ) begin
                if (imem_ack) begin
                    instr_reg <= imem_rdata;
                    state     <= ISSUE;
                end
            end else begin
                // acks arriving here are ignored; the IR only loads in REQ
                if (!stall) begin
                    pc_reg        <= next_pc;
                    align_err_reg <= misaligned;
                    state         <= REQ;
                end
            end
        end
    end

    // Request is gated by reset so it drops the instant reset asserts.
    assign imem_req    = (state == REQ) && !reset;
    assign imem_addr   = pc_reg;
    assign instr_valid = (state == ISSUE);
    assign pc          = pc_reg;
    assign align_err   = align_err_reg;

    assign opcode = instr_reg[31:26];
    assign rs     = instr_reg[25:21];
    assign rt     = instr_reg[20:16];
    assign rd     = instr_reg[15:11];
    assign shamt  = instr_reg[10:6];
    assign funct  = instr_reg[5:0];
    assign imm    = instr_reg[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of expected fetch addresses.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        stall;
    logic [31:0] rs_data;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        align_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .rs_data     (rs_data),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .funct       (funct),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .imm         (imm),
        .pc          (pc),
        .align_err   (align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] a, input logic [31:0] i,
                                               input logic [31:0] r);
        logic [31:0] s;
        s = a + 32'd4;
        if (i[31:26] == 6'h02) return {s[31:28], i[25:0], 2'b00};
        if (i[31:26] == 6'h00 && i[5:0] == 6'h08) return r & 32'hFFFF_FFFC;
        return s;
    endfunction

    task automatic check_fields(input string tag, input logic [31:0] i, input logic [31:0] a);
        chk({tag, "_valid"}, instr_valid, 1'b1);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_opcode"}, opcode, i[31:26]);
        chk({tag, "_funct"}, funct, i[5:0]);
        chk({tag, "_rs"}, rs, i[25:21]);
        chk({tag, "_rt"}, rt, i[20:16]);
        chk({tag, "_rd"}, rd, i[15:11]);
        chk({tag, "_shamt"}, shamt, i[10:6]);
        chk({tag, "_imm"}, imm, i[15:0]);
        chk({tag, "_pc"}, pc, a);
    endtask

    // Called at a negedge in REQ; returns at the negedge of the following REQ.
    task automatic do_fetch(input string tag, input logic [31:0] instr, input logic [31:0] rsd,
                            input int waits, input int stalls, input logic stray);
        logic [31:0] a;
        logic        exp_align;
        a = exp_q.pop_front();
        chk({tag, "_req"}, imem_req, 1'b1);
        chk({tag, "_addr"}, imem_addr, a);
        chk({tag, "_nvalid"}, instr_valid, 1'b0);
        for (int w = 0; w < waits; w++) begin
            stall = 1'b1;
            @(negedge clk);
            chk({tag, "_wreq"}, imem_req, 1'b1);
            chk({tag, "_waddr"}, imem_addr, a);
            chk({tag, "_wvalid"}, instr_valid, 1'b0);
            chk({tag, "_walign"}, align_err, 1'b0);
        end
        stall      = 1'b0;
        imem_rdata = instr;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_fields(tag, instr, a);
        for (int s = 0; s < stalls; s++) begin
            stall = 1'b1;
            if (stray && s == 1) begin
                imem_rdata = ~instr;
                imem_ack   = 1'b1;
            end
            @(negedge clk);
            imem_ack = 1'b0;
            check_fields({tag, "_stl"}, instr, a);
            chk({tag, "_stlalign"}, align_err, 1'b0);
        end
        stall   = 1'b0;
        rs_data = rsd;
        exp_align = (instr[31:26] == 6'h00) && (instr[5:0] == 6'h08) && (rsd[1:0] != 2'b00);
        exp_q.push_back(model_next(a, instr, rsd));
        @(negedge clk);
        rs_data = 32'h0;
        chk({tag, "_align"}, align_err, exp_align);
    endtask

    initial begin
        reset      = 1'b1;
        imem_rdata = 32'h0;
        imem_ack   = 1'b0;
        stall      = 1'b0;
        rs_data    = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_align", align_err, 1'b0);
        chk("rst_opcode", opcode, 6'h00);
        chk("rst_imm", imem_addr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        reset = 1'b0;
        exp_q.push_back(32'h0000_0000);
        @(negedge clk);

        do_fetch("add", 32'h012A_4020, 32'h0, 0, 0, 1'b0);
        chk("add_fixed_funct", funct, 6'h20);
        chk("add_fixed_rs", rs, 5'd9);
        chk("add_fixed_rt", rt, 5'd10);
        chk("add_fixed_rd", rd, 5'd8);
        chk("add_next", imem_addr, 32'h4);

        do_fetch("jr10", 32'h03E0_0008, 32'h0000_0010, 0, 0, 1'b0);
        chk("jr10_next", imem_addr, 32'h10);
        do_fetch("j", 32'h0800_0100, 32'h0, 0, 0, 1'b0);
        chk("j_next", imem_addr, 32'h400);
        do_fetch("jr42", 32'h03E0_0008, 32'h0000_0042, 0, 0, 1'b0);
        chk("jr42_next", imem_addr, 32'h40);
        do_fetch("jr40", 32'h03E0_0008, 32'h0000_0040, 1, 0, 1'b0);
        chk("jr40_next", imem_addr, 32'h40);
        do_fetch("lw_wait_stall", 32'h8C22_0004, 32'h0, 5, 3, 1'b1);
        chk("stall_next", imem_addr, 32'h44);
        do_fetch("jrtop", 32'h03E0_0008, 32'hFFFF_FFFC, 0, 0, 1'b0);
        do_fetch("wrap", 32'h2042_0001, 32'h0, 0, 0, 1'b0);
        chk("wrap_next", imem_addr, 32'h0);
        do_fetch("unknown", 32'hFC00_1234, 32'h0, 0, 0, 1'b0);

        // Reset in the middle of a request; an ack while in reset must not land.
        reset = 1'b1;
        #1;
        chk("mrst_req", imem_req, 1'b0);
        chk("mrst_pc", pc, 32'h0);
        @(negedge clk);
        imem_rdata = 32'h0800_0ABC;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        reset    = 1'b0;
        #1;
        chk("mrst_rel_req", imem_req, 1'b1);
        chk("mrst_rel_addr", imem_addr, 32'h0);
        chk("mrst_rel_valid", instr_valid, 1'b0);
        chk("mrst_rel_opcode", opcode, 6'h00);
        exp_q.delete();
        exp_q.push_back(32'h0000_0000);
        @(negedge clk);
        do_fetch("refetch", 32'h012A_4020, 32'h0, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
